// File: rtl/ad9363_rx_pkg.sv
// Shared types and constants for the AD9363 receive loopback monitor.
// No logic is held here, so there is no latency and no backpressure.
package ad9363_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam int SAMPLE_W  = 12;
    localparam int ACC_W     = 28;
    localparam int GAP_TMR_W = 4;

    localparam logic [GAP_TMR_W-1:0] GAP_1R1T = 4'd2;
    localparam logic [GAP_TMR_W-1:0] GAP_2R2T = 4'd4;

    // Unsigned magnitude: -2048 maps to 12'h800 (2048) rather than wrapping.
    function automatic logic [SAMPLE_W-1:0] abs12(input logic [SAMPLE_W-1:0] x);
        return x[SAMPLE_W-1] ? ((~x) + SAMPLE_W'(1)) : x;
    endfunction

endpackage

// File: rtl/ad9363_rx_chan_stat.sv
// Per-channel I/Q peak magnitude and positive zero-crossing count on I.
// Updates on the edge after accept; no backpressure, every accepted set is consumed.
module ad9363_rx_chan_stat
    import ad9363_rx_pkg::*;
#(
    parameter int WIN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                accept,
    input  logic [SAMPLE_W-1:0] data_i,
    input  logic [SAMPLE_W-1:0] data_q,
    output logic [SAMPLE_W-1:0] peak_i,
    output logic [SAMPLE_W-1:0] peak_q,
    output logic [WIN_W-1:0]    zc
);

    logic [SAMPLE_W-1:0] abs_i;
    logic [SAMPLE_W-1:0] abs_q;
    logic                prev_neg;

    assign abs_i = abs12(data_i);
    assign abs_q = abs12(data_q);

    // prev_neg clears to 0, so the first sample of a window can never count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            peak_i   <= '0;
            peak_q   <= '0;
            zc       <= '0;
            prev_neg <= 1'b0;
        end else if (accept) begin
            if (abs_i > peak_i) peak_i <= abs_i;
            if (abs_q > peak_q) peak_q <= abs_q;
            if (prev_neg && !data_i[SAMPLE_W-1]) zc <= zc + WIN_W'(1);
            prev_neg <= data_i[SAMPLE_W-1];
        end
    end

endmodule

// File: rtl/ad9363_rx_monitor.sv
// AD9363 RX loopback checker: windowed peak, zero-crossing, I0 DC sum and cadence errors.
// Results and done appear the cycle after the last accepted set; input is never stalled.
module ad9363_rx_monitor
    import ad9363_rx_pkg::*;
#(
    parameter int WIN_W     = 16,
    parameter int GAP_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_1r1t,
    input  logic                 rx_status,
    input  logic                 adc_valid,
    input  logic [11:0]          adc_data_i0,
    input  logic [11:0]          adc_data_q0,
    input  logic [11:0]          adc_data_i1,
    input  logic [11:0]          adc_data_q1,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    output logic                 busy,
    output logic                 done,
    output logic                 status_lost,
    output logic [11:0]          peak_i0,
    output logic [11:0]          peak_q0,
    output logic [11:0]          peak_i1,
    output logic [11:0]          peak_q1,
    output logic [WIN_W-1:0]     zc_i0,
    output logic [WIN_W-1:0]     zc_i1,
    output logic [27:0]          dc_sum_i0,
    output logic [GAP_CNT_W-1:0] gap_err_cnt
);

    state_t state, state_nxt;
    logic clear, accept, abort;

    logic                 mode_q;
    logic [WIN_W-1:0]     win_len_q;
    logic [WIN_W-1:0]     sample_cnt;
    logic [GAP_TMR_W-1:0] gap_tmr;
    logic [GAP_TMR_W-1:0] exp_gap;
    logic [GAP_CNT_W-1:0] gap_acc;
    logic [ACC_W-1:0]     dc_acc;
    logic                 lost_q;

    logic [SAMPLE_W-1:0]  c0_peak_i, c0_peak_q, c1_peak_i, c1_peak_q;
    logic [WIN_W-1:0]     c0_zc, c1_zc;

    logic [SAMPLE_W-1:0]  res_peak_i0, res_peak_q0, res_peak_i1, res_peak_q1;
    logic [WIN_W-1:0]     res_zc_i0, res_zc_i1;
    logic [ACC_W-1:0]     res_dc;
    logic [GAP_CNT_W-1:0] res_gap;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && window_len != '0) begin
                    clear     = 1'b1;
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rx_status) state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                // Losing lock wins over a coincident final sample.
                if (!rx_status) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (adc_valid) begin
                    accept = 1'b1;
                    if (sample_cnt == win_len_q - WIN_W'(1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign exp_gap = mode_q ? GAP_1R1T : GAP_2R2T;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            win_len_q  <= '0;
            sample_cnt <= '0;
            gap_tmr    <= '0;
            gap_acc    <= '0;
            dc_acc     <= '0;
            lost_q     <= 1'b0;
        end else if (clear) begin
            mode_q     <= mode_1r1t;
            win_len_q  <= window_len;
            sample_cnt <= '0;
            gap_tmr    <= '0;
            gap_acc    <= '0;
            dc_acc     <= '0;
            lost_q     <= 1'b0;
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + WIN_W'(1);
                gap_tmr    <= GAP_TMR_W'(1);
                // gap_tmr holds the clock distance since the previous accepted set.
                if (sample_cnt != '0 && gap_tmr != exp_gap && gap_acc != '1)
                    gap_acc <= gap_acc + GAP_CNT_W'(1);
                dc_acc <= dc_acc + {{(ACC_W-SAMPLE_W){adc_data_i0[SAMPLE_W-1]}}, adc_data_i0};
            end else if (gap_tmr != '1) begin
                gap_tmr <= gap_tmr + GAP_TMR_W'(1);
            end
            if (abort) lost_q <= 1'b1;
        end
    end

    ad9363_rx_chan_stat #(.WIN_W(WIN_W)) u_chan0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .accept (accept),
        .data_i (adc_data_i0),
        .data_q (adc_data_q0),
        .peak_i (c0_peak_i),
        .peak_q (c0_peak_q),
        .zc     (c0_zc)
    );

    ad9363_rx_chan_stat #(.WIN_W(WIN_W)) u_chan1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .accept (accept && !mode_q),
        .data_i (adc_data_i1),
        .data_q (adc_data_q1),
        .peak_i (c1_peak_i),
        .peak_q (c1_peak_q),
        .zc     (c1_zc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_peak_i0 <= '0;
            res_peak_q0 <= '0;
            res_peak_i1 <= '0;
            res_peak_q1 <= '0;
            res_zc_i0   <= '0;
            res_zc_i1   <= '0;
            res_dc      <= '0;
            res_gap     <= '0;
        end else if (state == ST_DONE) begin
            res_peak_i0 <= c0_peak_i;
            res_peak_q0 <= c0_peak_q;
            res_peak_i1 <= c1_peak_i;
            res_peak_q1 <= c1_peak_q;
            res_zc_i0   <= c0_zc;
            res_zc_i1   <= c1_zc;
            res_dc      <= dc_acc;
            res_gap     <= gap_acc;
        end
    end

    // In DONE the accumulators already hold the final window, so they drive the outputs directly.
    assign busy        = (state == ST_ARM) || (state == ST_MEASURE);
    assign done        = (state == ST_DONE);
    assign status_lost = lost_q;
    assign peak_i0     = done ? c0_peak_i : res_peak_i0;
    assign peak_q0     = done ? c0_peak_q : res_peak_q0;
    assign peak_i1     = done ? c1_peak_i : res_peak_i1;
    assign peak_q1     = done ? c1_peak_q : res_peak_q1;
    assign zc_i0       = done ? c0_zc     : res_zc_i0;
    assign zc_i1       = done ? c1_zc     : res_zc_i1;
    assign dc_sum_i0   = done ? dc_acc    : res_dc;
    assign gap_err_cnt = done ? gap_acc   : res_gap;

endmodule

// File: tb/tb_ad9363_rx_monitor.sv
// Scoreboard bench for ad9363_rx_monitor: expected window results are queued as samples are driven
// and compared when done pulses; scenario tasks check control behaviour inline.
module tb_ad9363_rx_monitor;

    localparam int WIN_W     = 16;
    localparam int GAP_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mode_1r1t;
    logic                 rx_status;
    logic                 adc_valid;
    logic [11:0]          adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1;
    logic                 start;
    logic [WIN_W-1:0]     window_len;
    logic                 busy, done, status_lost;
    logic [11:0]          peak_i0, peak_q0, peak_i1, peak_q1;
    logic [WIN_W-1:0]     zc_i0, zc_i1;
    logic [27:0]          dc_sum_i0;
    logic [GAP_CNT_W-1:0] gap_err_cnt;

    ad9363_rx_monitor #(.WIN_W(WIN_W), .GAP_CNT_W(GAP_CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_1r1t   (mode_1r1t),
        .rx_status   (rx_status),
        .adc_valid   (adc_valid),
        .adc_data_i0 (adc_data_i0),
        .adc_data_q0 (adc_data_q0),
        .adc_data_i1 (adc_data_i1),
        .adc_data_q1 (adc_data_q1),
        .start       (start),
        .window_len  (window_len),
        .busy        (busy),
        .done        (done),
        .status_lost (status_lost),
        .peak_i0     (peak_i0),
        .peak_q0     (peak_q0),
        .peak_i1     (peak_i1),
        .peak_q1     (peak_q1),
        .zc_i0       (zc_i0),
        .zc_i1       (zc_i1),
        .dc_sum_i0   (dc_sum_i0),
        .gap_err_cnt (gap_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pi0; int pq0; int pi1; int pq1;
        int zc0; int zc1; int dc;  int gap;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp = '{default: 0};
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   pushes   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Channel order: 0=I0, 1=Q0, 2=I1, 3=Q1.
    function automatic int gen(input int pat, input int ch, input int k);
        if (pat == 0) begin
            if (ch == 0) return (k % 2 == 0) ? 100 : -100;
            if (ch == 1) return k * 37 - 50;
            if (ch == 2) return k * 11 + 3;
            return -(k * 5) - 1;
        end
        if (pat == 1) begin
            if (ch == 0 || ch == 3) return -2048;
            if (ch == 1) return k;
            return -k;
        end
        return int'($urandom_range(4095)) - 2048;
    endfunction

    // Scoreboard consumer: every done pulse pops one expected window.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done with empty scoreboard, want none");
            end else begin
                e = sb.pop_front();
                last_exp = e;
                checks++; if (peak_i0 !== 12'(e.pi0)) begin failures++; $display("FAIL peak_i0: got %0d want %0d", peak_i0, e.pi0); end
                checks++; if (peak_q0 !== 12'(e.pq0)) begin failures++; $display("FAIL peak_q0: got %0d want %0d", peak_q0, e.pq0); end
                checks++; if (peak_i1 !== 12'(e.pi1)) begin failures++; $display("FAIL peak_i1: got %0d want %0d", peak_i1, e.pi1); end
                checks++; if (peak_q1 !== 12'(e.pq1)) begin failures++; $display("FAIL peak_q1: got %0d want %0d", peak_q1, e.pq1); end
                checks++; if (zc_i0 !== 16'(e.zc0)) begin failures++; $display("FAIL zc_i0: got %0d want %0d", zc_i0, e.zc0); end
                checks++; if (zc_i1 !== 16'(e.zc1)) begin failures++; $display("FAIL zc_i1: got %0d want %0d", zc_i1, e.zc1); end
                checks++; if (dc_sum_i0 !== 28'(e.dc)) begin failures++; $display("FAIL dc_sum_i0: got %0d want %0d", $signed(dc_sum_i0), e.dc); end
                checks++; if (gap_err_cnt !== 8'(e.gap)) begin failures++; $display("FAIL gap_err_cnt: got %0d want %0d", gap_err_cnt, e.gap); end
                checks++; if (busy !== 1'b0 || status_lost !== 1'b0) begin failures++; $display("FAIL done_flags: got busy=%b lost=%b want 0 0", busy, status_lost); end
            end
        end
    end

    // Runs one full window; odd_idx picks the set followed by an irregular spacing odd_sp,
    // start_at picks a set driven together with a (to be ignored) start.
    task automatic drive_window(input bit mode, input int wl, input int pat, input int sp,
                                input int odd_idx, input int odd_sp, input int start_at,
                                output logic done_now);
        exp_t e;
        int   s[4];
        int   prev[4];
        int   exp_gap;
        int   gsp;
        e = '{default: 0};
        exp_gap = mode ? 2 : 4;
        mode_1r1t = mode; window_len = 16'(wl); start = 1'b1;
        tick;
        start = 1'b0; mode_1r1t = !mode; window_len = '1;
        tick;
        for (int k = 0; k < wl; k++) begin
            for (int c = 0; c < 4; c++) s[c] = gen(pat, c, k);
            adc_data_i0 = 12'(s[0]); adc_data_q0 = 12'(s[1]);
            adc_data_i1 = 12'(s[2]); adc_data_q1 = 12'(s[3]);
            adc_valid = 1'b1;
            if (k == start_at) begin start = 1'b1; window_len = 16'd2; end
            e.pi0 = imax(e.pi0, iabs(s[0]));
            e.pq0 = imax(e.pq0, iabs(s[1]));
            if (k > 0 && prev[0] < 0 && s[0] >= 0) e.zc0++;
            if (!mode) begin
                e.pi1 = imax(e.pi1, iabs(s[2]));
                e.pq1 = imax(e.pq1, iabs(s[3]));
                if (k > 0 && prev[2] < 0 && s[2] >= 0) e.zc1++;
            end
            e.dc += s[0];
            for (int c = 0; c < 4; c++) prev[c] = s[c];
            tick;
            adc_valid = 1'b0; start = 1'b0;
            if (k < wl - 1) begin
                gsp = (k == odd_idx) ? odd_sp : sp;
                repeat (gsp - 1) tick;
                if (gsp != exp_gap) e.gap = (e.gap < 255) ? e.gap + 1 : 255;
            end
        end
        sb.push_back(e);
        pushes++;
        done_now = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mode_1r1t = 1'b0; rx_status = 1'b1; adc_valid = 1'b0; start = 1'b0;
        window_len = '0; adc_data_i0 = '0; adc_data_q0 = '0; adc_data_i1 = '0; adc_data_q1 = '0;
        repeat (2) tick;
        checks++;
        if ({busy, done, status_lost, peak_i0, peak_q0, peak_i1, peak_q1, zc_i0, zc_i1, dc_sum_i0, gap_err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b lost=%b pi0=%0d dc=%0d gap=%0d want all 0",
                     busy, done, status_lost, peak_i0, dc_sum_i0, gap_err_cnt);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_1r1t_tone;
        logic d;
        drive_window(1'b1, 8, 0, 2, -1, 0, -1, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL 1r1t_done_latency: got done=%b want 1", d); end
        start = 1'b1; window_len = 16'd3;
        tick;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL start_in_done: got busy=%b done=%b want 0 0", busy, done); end
        repeat (2) tick;
    endtask

    task automatic test_2r2t_full_scale;
        logic d;
        drive_window(1'b0, 4, 1, 4, -1, 0, -1, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL full_scale_done: got done=%b want 1", d); end
        repeat (2) tick;
    endtask

    task automatic test_gap_err;
        logic d;
        drive_window(1'b0, 6, 2, 4, 2, 6, -1, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL gap_err_done: got done=%b want 1", d); end
        repeat (2) tick;
    endtask

    task automatic test_status_loss(input int wl, input int drop_k);
        exp_t saved;
        int   dc0;
        saved = last_exp; dc0 = done_cnt;
        mode_1r1t = 1'b0; window_len = 16'(wl); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        for (int k = 0; k < drop_k; k++) begin
            adc_data_i0 = 12'(gen(2, 0, k)); adc_data_q0 = 12'(gen(2, 1, k));
            adc_data_i1 = 12'(gen(2, 2, k)); adc_data_q1 = 12'(gen(2, 3, k));
            adc_valid = 1'b1;
            tick;
            adc_valid = 1'b0;
            repeat (3) tick;
        end
        adc_data_i0 = 12'h7FF; adc_valid = 1'b1; rx_status = 1'b0;
        tick;
        adc_valid = 1'b0; rx_status = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loss_busy: got %b want 0", busy); end
        checks++; if (status_lost !== 1'b1) begin failures++; $display("FAIL loss_flag: got %b want 1", status_lost); end
        checks++; if (peak_i0 !== 12'(saved.pi0) || dc_sum_i0 !== 28'(saved.dc) || gap_err_cnt !== 8'(saved.gap)) begin
            failures++;
            $display("FAIL loss_results_held: got pi0=%0d dc=%0d gap=%0d want %0d %0d %0d",
                     peak_i0, $signed(dc_sum_i0), gap_err_cnt, saved.pi0, saved.dc, saved.gap);
        end
        repeat (4) tick;
        checks++; if (done_cnt != dc0 || busy !== 1'b0) begin failures++; $display("FAIL loss_no_done: got done_cnt=%0d busy=%b want %0d 0", done_cnt, busy, dc0); end
    endtask

    task automatic test_ignore;
        logic d;
        window_len = '0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_len_start: got busy=%b want 0", busy); end
        tick;
        drive_window(1'b0, 4, 2, 4, -1, 0, 1, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL start_while_busy: got done=%b want 1", d); end
        repeat (2) tick;
    endtask

    task automatic test_gap_saturate;
        logic d;
        drive_window(1'b0, 300, 2, 1, -1, 0, -1, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL saturate_done: got done=%b want 1", d); end
        repeat (2) tick;
    endtask

    task automatic test_reset_mid;
        logic d;
        mode_1r1t = 1'b0; window_len = 16'd16; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        for (int k = 0; k < 3; k++) begin
            adc_data_i0 = 12'h123; adc_valid = 1'b1;
            tick;
            adc_valid = 1'b0;
            repeat (3) tick;
        end
        rst_n = 1'b0;
        tick;
        checks++; if ({busy, done, status_lost} !== 3'b000) begin failures++; $display("FAIL midreset_flags: got %b want 000", {busy, done, status_lost}); end
        checks++;
        if ({peak_i0, peak_q0, peak_i1, peak_q1, zc_i0, zc_i1, dc_sum_i0, gap_err_cnt} !== '0) begin
            failures++;
            $display("FAIL midreset_results: got pi0=%0d pq0=%0d dc=%0d gap=%0d want 0", peak_i0, peak_q0, dc_sum_i0, gap_err_cnt);
        end
        rst_n = 1'b1;
        tick;
        drive_window(1'b0, 4, 2, 4, -1, 0, -1, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL midreset_fresh_run: got done=%b want 1", d); end
        repeat (2) tick;
    endtask

    initial begin
        test_reset();
        test_1r1t_tone();
        test_2r2t_full_scale();
        test_gap_err();
        test_status_loss(16, 5);
        test_status_loss(6, 5);
        test_ignore();
        test_gap_saturate();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        checks++; if (done_cnt != pushes) begin failures++; $display("FAIL done_count: got %0d want %0d", done_cnt, pushes); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ad9363_rx_monitor.md
# ad9363_rx_monitor

Receive-side loopback checker for the AD9363 test path. It consumes the ADC sample stream (`adc_valid`, `adc_data_*`) that the DDS transmit generator loops back through the RF front end. Over a programmable window of valid sample sets it measures per-channel peak magnitude, positive zero-crossing count, I0 DC sum and sample-cadence errors. Results are latched for software or ILA readout; the block sits alongside the DDS transmit generator in the same clock domain.

## Interface
- `WIN_W`, default 16: width of `window_len` and of the zero-crossing counters.
- `GAP_CNT_W`, default 8: width of the saturating cadence-error counter.
- `clk` in 1: sample clock, the same clock as the ADC/DAC data interface.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `mode_1r1t` in 1: 1 = one RX channel, 0 = two RX channels; sampled at `start`.
- `rx_status` in 1: RX interface locked/valid.
- `adc_valid` in 1: one sample set per high cycle.
- `adc_data_i0`, `adc_data_q0`, `adc_data_i1`, `adc_data_q1` in 12 each: two's-complement samples.
- `start` in 1: single-cycle measurement request.
- `window_len` in `WIN_W`: sample sets per measurement; sampled at `start`.
- `busy` out 1: high in ARM and MEASURE.
- `done` out 1: one-cycle pulse when results update.
- `status_lost` out 1: the last run aborted on `rx_status` loss.
- `peak_i0`, `peak_q0`, `peak_i1`, `peak_q1` out 12 each: unsigned max |sample|.
- `zc_i0`, `zc_i1` out `WIN_W` each: positive-going zero crossings on I.
- `dc_sum_i0` out 28: signed sum of I0 samples.
- `gap_err_cnt` out `GAP_CNT_W`: saturating count of cadence violations.

## Operation
- State machine states are IDLE, ARM, MEASURE and DONE. Reset enters IDLE.
- IDLE:
  - `start`=1 with `window_len`≠0 → ARM.
  - On that transition: latch `mode_1r1t` and `window_len`, clear all accumulators, clear `status_lost`.
  - `start` with `window_len`=0 is ignored.
  - `start` outside IDLE is ignored.
- ARM:
  - `rx_status`=1 → MEASURE. Otherwise stay in ARM; there is no timeout.
- MEASURE:
  - Each `adc_valid` cycle accepts one sample set and increments the sample counter.
  - The Nth accepted set (N = latched `window_len`) → DONE.
  - `rx_status`=0 in any MEASURE cycle → IDLE. `status_lost`=1. No `done`. Result outputs keep their previous values.
- DONE: copy accumulators to the result outputs, pulse `done`, → IDLE.
- Magnitude:
  - |x| is computed in 12-bit unsigned, so -2048 → 2048.
  - The peak holds the running maximum.
- Zero crossing: counted when the previous accepted sample on the same channel has bit 11 = 1 and the current sample has bit 11 = 0. The first sample of a window never counts.
- DC: `dc_sum_i0` sign-extends each I0 sample to 28 bits and accumulates. 28 bits covers 65535 × ±2048 without overflow.
- 1r1t: channel-1 inputs are ignored. `peak_i1`, `peak_q1` and `zc_i1` report 0.
- Cadence check:
  - Expected spacing between accepted sets is 2 clocks (1r1t) or 4 clocks (2r2t).
  - A gap counter starts at the first accepted set. Each later set whose spacing ≠ expected increments `gap_err_cnt`.
  - `gap_err_cnt` saturates at all-ones.
  - A gap that spans the final sample is still checked.

## Timing
- Reset value of every output is 0.
- `start` at cycle t → `busy`=1 at t+1 (ARM).
- The ARM→MEASURE transition costs one cycle. `adc_valid` in the transition cycle is not accepted.
- Last sample accepted at cycle t → DONE at t+1, with `done`=1 and results valid from t+1. `busy`=0 at t+1.
- Results hold until the next successful completion.
- `rst_n`=0 in any state: → IDLE at the next edge and all outputs return to 0. This includes mid-measurement reset.
- Simultaneous events in MEASURE:
  - `rx_status` drop takes priority over the final sample; that run aborts.
  - A `start` in the DONE cycle is ignored.

## Structure
- Package `ad9363_rx_pkg` holds:
  - the state enum;
  - sample width 12 and accumulator width 28;
  - expected-gap constants `GAP_1R1T`=2 and `GAP_2R2T`=4.
- Sub-module `ad9363_rx_chan_stat` is instantiated twice (channel 0, channel 1). It provides:
  - I/Q abs and peak registers;
  - previous-sign register and zero-crossing counter;
  - inputs `clear` and `accept`.
- The top level owns the FSM, the sample counter, the gap counter, the DC accumulator and the result registers.

## Test plan
- 1r1t, `window_len`=8, valid every 2 clocks, I0 = +100, -100, … → `done` once, `zc_i0`=3, `peak_i0`=100, `dc_sum_i0`=0, `gap_err_cnt`=0, `peak_i1`=0.
- 2r2t, `window_len`=4, I0 = Q1 = -2048 constant, valid every 4 clocks → `peak_i0`=`peak_q1`=2048, `dc_sum_i0`=-8192, `zc_i0`=0.
- 2r2t, `window_len`=6, one spacing of 6 clocks instead of 4 → `gap_err_cnt`=1, other results as for regular cadence.
- Run with `window_len`=16, drop `rx_status` after 5 samples → return to IDLE, `status_lost`=1, no `done`, results unchanged from the prior run.
- `rst_n`=0 mid-MEASURE → all outputs 0 next cycle. A fresh `start` then completes normally.
- `start` with `window_len`=0, and `start` while `busy` → both ignored, no state change.
